// File: rtl/ecc_encode_control.sv
// Write-path ECC frame controller: gathers K information bits, hands them to the LDPC
// encoder core, latches the parity and streams {data, parity} words to the flash path.
module ecc_encode_control #(
    parameter int K = 8192,
    parameter int M = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ecc_encode_req,
    input  logic          wr_en,
    input  logic [31:0]   data_in,
    output logic          ecc_encode_rdy,
    output logic [K-1:0]  enc_data,
    output logic          ecc_encode_sta,
    input  logic          ecc_encode_over,
    input  logic [M-1:0]  parity_in,
    input  logic          rd_en,
    output logic [31:0]   data_out,
    output logic          data_out_vld,
    output logic          encode_output_over
);

    localparam int N      = K + M;
    localparam int DW_CNT = K / 32;
    localparam int CW_CNT = N / 32;
    localparam int WCW    = $clog2(DW_CNT + 1);
    localparam int RCW    = $clog2(CW_CNT + 1);

    typedef enum logic [1:0] {S_LOAD, S_ENC, S_OUT, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WCW-1:0]  wcnt;
    logic [RCW-1:0]  rcnt;
    logic [M-1:0]    parity;
    logic [31:0]     rd_word;
    logic            load_wr;
    logic            last_wr;
    logic            enc_done;
    logic            out_rd;
    logic            last_rd;

    // Every qualifier includes req so an abort outranks any other event in the same cycle.
    assign load_wr  = (state == S_LOAD) && ecc_encode_req && wr_en;
    assign last_wr  = load_wr && (wcnt == WCW'(DW_CNT - 1));
    assign enc_done = (state == S_ENC) && ecc_encode_req && ecc_encode_over;
    assign out_rd   = (state == S_OUT) && ecc_encode_req && rd_en;
    assign last_rd  = out_rd && (rcnt == RCW'(CW_CNT - 1));

    assign ecc_encode_rdy     = (state == S_LOAD);
    assign ecc_encode_sta     = (state == S_ENC);
    assign encode_output_over = (state == S_DONE);

    // NOTE: state register only; all transition logic lives in the combinational process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (!ecc_encode_req) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (last_wr)         state_nxt = S_ENC;
                S_ENC:   if (ecc_encode_over) state_nxt = S_OUT;
                S_OUT:   if (last_rd)         state_nxt = S_DONE;
                S_DONE:                       state_nxt = S_LOAD;
                default:                      state_nxt = S_LOAD;
            endcase
        end
    end

    // Codeword order: data words first, then parity word 0 = parity[31:0].
    always_comb begin
        rd_word = '0;
        if (rcnt < RCW'(DW_CNT)) rd_word = enc_data[32*rcnt +: 32];
        else                     rd_word = parity[32*(rcnt - RCW'(DW_CNT)) +: 32];
    end

    // NOTE: frame and parity registers are cleared by reset so no stale frame is ever visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_data     <= '0;
            parity       <= '0;
            wcnt         <= '0;
            rcnt         <= '0;
            data_out     <= '0;
            data_out_vld <= 1'b0;
        end else begin
            data_out_vld <= 1'b0;
            if (load_wr) begin
                enc_data[32*wcnt +: 32] <= data_in;
                wcnt                    <= wcnt + 1'b1;
            end
            if (enc_done) begin
                parity <= parity_in;
                rcnt   <= '0;
            end
            if (out_rd) begin
                data_out     <= rd_word;
                data_out_vld <= 1'b1;
                rcnt         <= rcnt + 1'b1;
            end
            if (!ecc_encode_req || state == S_DONE) begin
                wcnt <= '0;
                rcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ecc_encode_control.sv
// Directed bench for ecc_encode_control: full frames, reset, overrun, throttled read,
// abort and spurious encoder-done pulses, all checked against bench-built word patterns.
module tb_ecc_encode_control;

    localparam int K = 8192;
    localparam int M = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ecc_encode_req = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   data_in = '0;
    logic          ecc_encode_over = 1'b0;
    logic [M-1:0]  parity_in = '0;
    logic          rd_en = 1'b0;
    logic          ecc_encode_rdy;
    logic [K-1:0]  enc_data;
    logic          ecc_encode_sta;
    logic [31:0]   data_out;
    logic          data_out_vld;
    logic          encode_output_over;

    int n_checks = 0;
    int n_pass   = 0;

    ecc_encode_control #(.K(K), .M(M)) dut (
        .clk                (clk),
        .rst                (rst),
        .ecc_encode_req     (ecc_encode_req),
        .wr_en              (wr_en),
        .data_in            (data_in),
        .ecc_encode_rdy     (ecc_encode_rdy),
        .enc_data           (enc_data),
        .ecc_encode_sta     (ecc_encode_sta),
        .ecc_encode_over    (ecc_encode_over),
        .parity_in          (parity_in),
        .rd_en              (rd_en),
        .data_out           (data_out),
        .data_out_vld       (data_out_vld),
        .encode_output_over (encode_output_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] db, input logic [31:0] pb, input int idx);
        return (idx < 256) ? db + 32'(idx) : pb + 32'(idx - 256);
    endfunction

    // spur_at >= 0 pulses ecc_encode_over with junk parity while that word is written.
    task automatic write_words(input logic [31:0] base, input int n, input int spur_at);
        for (int i = 0; i < n; i++) begin
            ecc_encode_req  = 1'b1;
            wr_en           = 1'b1;
            data_in         = base + 32'(i);
            ecc_encode_over = (i == spur_at);
            parity_in       = (i == spur_at) ? '1 : '0;
            step();
            if (i == spur_at) begin
                check("spur_sta", ecc_encode_sta, 1'b0);
                check("spur_rdy", ecc_encode_rdy, 1'b1);
            end
        end
        wr_en           = 1'b0;
        ecc_encode_over = 1'b0;
        parity_in       = '0;
    endtask

    task automatic encode(input logic [31:0] pb, input bit overrun);
        logic [M-1:0] par;
        check("enc_sta_up", ecc_encode_sta, 1'b1);
        check("enc_rdy_low", ecc_encode_rdy, 1'b0);
        for (int c = 0; c < 5; c++) begin
            wr_en   = overrun;
            data_in = 32'hEEEE_0000 + 32'(c);
            step();
            check("enc_sta_hold", ecc_encode_sta, 1'b1);
        end
        wr_en = 1'b0;
        for (int j = 0; j < 32; j++) par[32*j +: 32] = pb + 32'(j);
        ecc_encode_over = 1'b1;
        parity_in       = par;
        step();
        ecc_encode_over = 1'b0;
        parity_in       = '0;
        check("enc_sta_drop", ecc_encode_sta, 1'b0);
    endtask

    task automatic read_frame(input logic [31:0] db, input logic [31:0] pb, input bit throttle,
                              input int extra_wr);
        int got = 0;
        int cyc = 0;
        logic [31:0] last = '0;
        while (got < 288 && cyc < 2000) begin
            rd_en   = (got < 288) && (!throttle || (cyc % 4 == 0) || (cyc % 4 == 3));
            wr_en   = (cyc < extra_wr);
            data_in = 32'hFFFF_0000 + 32'(cyc);
            step();
            if (rd_en) begin
                check("out_vld", data_out_vld, 1'b1);
                check("out_word", data_out, exp_word(db, pb, got));
                last = exp_word(db, pb, got);
                got++;
            end else begin
                check("gap_vld", data_out_vld, 1'b0);
                if (got > 0) check("gap_hold", data_out, last);
            end
            cyc++;
        end
        if (got < 288) check("read_timeout", 32'(got), 32'd288);
        check("over_pulse", encode_output_over, 1'b1);
        rd_en = 1'b0;
        wr_en = 1'b0;
        step();
        check("over_clear", encode_output_over, 1'b0);
        check("back_rdy", ecc_encode_rdy, 1'b1);
        check("back_vld", data_out_vld, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", ecc_encode_rdy, 1'b1);
        check("rst_sta", ecc_encode_sta, 1'b0);
        check("rst_vld", data_out_vld, 1'b0);
        check("rst_over", encode_output_over, 1'b0);
        check("rst_dout", data_out, 32'h0);
        rst = 1'b0;
        step();

        // Full frame, free-running read.
        write_words(32'hA500_0000, 256, -1);
        encode(32'h5A00_0000, 1'b0);
        read_frame(32'hA500_0000, 32'h5A00_0000, 1'b0, 0);

        // Asynchronous reset after 50 words, then a clean frame from word 0.
        write_words(32'hC300_0000, 50, -1);
        #3 rst = 1'b1;
        #1;
        check("arst_rdy", ecc_encode_rdy, 1'b1);
        check("arst_sta", ecc_encode_sta, 1'b0);
        check("arst_vld", data_out_vld, 1'b0);
        check("arst_over", encode_output_over, 1'b0);
        check("arst_dout", data_out, 32'h0);
        check("arst_word0", enc_data[31:0], 32'h0);
        check("arst_word49", enc_data[1599:1568], 32'h0);
        step();
        rst = 1'b0;
        step();
        write_words(32'h1100_0000, 256, -1);
        encode(32'h2200_0000, 1'b0);
        read_frame(32'h1100_0000, 32'h2200_0000, 1'b0, 0);

        // Overrun: 5 writes during encode plus 15 during readout.
        write_words(32'hA500_0000, 256, -1);
        encode(32'h5A00_0000, 1'b1);
        read_frame(32'hA500_0000, 32'h5A00_0000, 1'b0, 15);

        // Throttled read, pattern 1,0,0,1.
        write_words(32'h3300_0000, 256, -1);
        encode(32'h4400_0000, 1'b0);
        read_frame(32'h3300_0000, 32'h4400_0000, 1'b1, 0);

        // Abort mid-load and mid-encode; the restart word arrives with req rising.
        write_words(32'h7700_0000, 100, -1);
        ecc_encode_req = 1'b0;
        step();
        check("abort_load_rdy", ecc_encode_rdy, 1'b1);
        check("abort_load_sta", ecc_encode_sta, 1'b0);
        write_words(32'h6600_0000, 256, -1);
        check("pre_abort_sta", ecc_encode_sta, 1'b1);
        ecc_encode_req = 1'b0;
        step();
        check("abort_enc_rdy", ecc_encode_rdy, 1'b1);
        check("abort_enc_sta", ecc_encode_sta, 1'b0);
        write_words(32'h8800_0000, 256, -1);
        encode(32'h9900_0000, 1'b0);
        read_frame(32'h8800_0000, 32'h9900_0000, 1'b0, 0);

        // Spurious encoder-done at word 10 of the load phase.
        write_words(32'hB100_0000, 256, 10);
        encode(32'h5A00_0000, 1'b0);
        read_frame(32'hB100_0000, 32'h5A00_0000, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
